// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM bank: channel modes and config field widths.
package led_pkg;

   localparam int MODE_W = 2;
   localparam int CH_W   = 5;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, breathe ramp, duty select and PWM compare.
// The active copy and the ramp only move on a frame boundary, so the duty seen
// by the comparator is constant for a whole PWM frame.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [MODE_W-1:0]   wr_mode,
   input  logic [PWM_BITS-1:0] wr_level,
   input  logic                frame,
   input  logic                blink_phase,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                lit
);

   led_mode_e           sh_mode, act_mode, sh_mode_nxt;
   logic [PWM_BITS-1:0] sh_level, act_level, sh_level_nxt;
   logic [PWM_BITS-1:0] ramp, ramp_nxt, duty;
   logic                ramp_up, ramp_up_nxt, go_up;

   // A write landing on the boundary cycle must be the value copied in.
   assign sh_mode_nxt  = wr_en ? led_mode_e'(wr_mode) : sh_mode;
   assign sh_level_nxt = wr_en ? wr_level : sh_level;

   // Next breathe ramp value, limited by the level that becomes active at this boundary.
   always_comb begin
      ramp_nxt    = ramp;
      ramp_up_nxt = ramp_up;
      go_up       = 1'b0;
      if (sh_level_nxt == '0) begin
         ramp_nxt = '0;
      end else if (ramp > sh_level_nxt) begin
         ramp_nxt = sh_level_nxt;
      end else if (act_mode == MODE_BREATHE) begin
         go_up = ramp_up ? (ramp < sh_level_nxt) : (ramp == '0);
         if (go_up) begin
            ramp_nxt    = ramp + 1'b1;
            ramp_up_nxt = (ramp_nxt != sh_level_nxt);
         end else begin
            ramp_nxt    = ramp - 1'b1;
            ramp_up_nxt = (ramp_nxt == '0);
         end
      end
   end

   // Shadow capture on write; active config and ramp advance on frame boundaries.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sh_mode   <= MODE_OFF;
         sh_level  <= '0;
         act_mode  <= MODE_OFF;
         act_level <= '0;
         ramp      <= '0;
         ramp_up   <= 1'b1;
      end else begin
         sh_mode  <= sh_mode_nxt;
         sh_level <= sh_level_nxt;
         if (frame) begin
            act_mode  <= sh_mode_nxt;
            act_level <= sh_level_nxt;
            ramp      <= ramp_nxt;
            ramp_up   <= ramp_up_nxt;
         end
      end
   end

   // Effective duty for the current frame.
   always_comb begin
      duty = '0;
      case (act_mode)
         MODE_OFF:     duty = '0;
         MODE_ON:      duty = act_level;
         MODE_BLINK:   duty = blink_phase ? act_level : '0;
         MODE_BREATHE: duty = ramp;
         default:      duty = '0;
      endcase
   end

   assign lit = (pwm_cnt < duty);

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM driver. Holds the shared prescaler, PWM counter and
// blink timebase, and registers the pins; per-channel logic lives in led_pwm_channel.
module led_pwm_bank
   import led_pkg::*;
#(
   parameter int N_LEDS       = 6,
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE     = 64,
   parameter int BLINK_FRAMES = 128,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_wr_en,
   input  logic [CH_W-1:0]     i_wr_ch,
   input  logic [MODE_W-1:0]   i_wr_mode,
   input  logic [PWM_BITS-1:0] i_wr_level,
   output logic                o_frame,
   output logic [N_LEDS-1:0]   o_led
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [BF_W-1:0]     BF_LAST = BF_W'(BLINK_FRAMES - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam logic [N_LEDS-1:0]   PIN_INV = {N_LEDS{ACTIVE_LOW}};

   logic [PS_W-1:0]     presc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [BF_W-1:0]     blink_cnt;
   logic                blink_phase;
   logic                tick, frame;
   logic [N_LEDS-1:0]   lit;

   assign tick    = (presc == PS_LAST);
   assign frame   = tick && (pwm_cnt == PWM_MAX);
   assign o_frame = frame;

   // Prescaler and free-running PWM counter; the counter wraps naturally at its width.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         presc   <= '0;
         pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
         presc   <= presc + 1'b1;
      end
   end

   // Bank-wide blink timebase; every blinking channel shares this phase.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame) begin
         if (blink_cnt == BF_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Channel indices at or above N_LEDS never match, so such writes are dropped.
   for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk_sys     (i_clk),
         .reset       (i_reset),
         .wr_en       (i_wr_en && (i_wr_ch == CH_W'(i))),
         .wr_mode     (i_wr_mode),
         .wr_level    (i_wr_level),
         .frame       (frame),
         .blink_phase (blink_phase),
         .pwm_cnt     (pwm_cnt),
         .lit         (lit[i])
      );
   end

   // Registered pins with board polarity applied; dark during reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_led <= PIN_INV;
      end else begin
         o_led <= lit ^ PIN_INV;
      end
   end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank: two instances (active-low and active-high pins) share
// the stimulus; a frame-level model is checked every cycle, and per-frame
// lit-cycle counts are checked against hand-computed duties.
module tb_led_pwm_bank;

   localparam int NC        = 6;
   localparam int PB        = 4;
   localparam int PS        = 1;
   localparam int BF        = 2;
   localparam int LEVELS    = 16;
   localparam int FRAME_CYC = PS * LEVELS;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_ch;
   logic [1:0]  wr_mode;
   logic [3:0]  wr_level;
   logic        frame_lo, frame_hi;
   logic [5:0]  led_lo, led_hi;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_pwm_bank #(
      .N_LEDS(NC), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
   ) dut_lo (
      .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
      .i_wr_mode(wr_mode), .i_wr_level(wr_level), .o_frame(frame_lo), .o_led(led_lo)
   );

   led_pwm_bank #(
      .N_LEDS(NC), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)
   ) dut_hi (
      .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
      .i_wr_mode(wr_mode), .i_wr_level(wr_level), .o_frame(frame_hi), .o_led(led_hi)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int   k;
   int   sh_mode[NC], sh_lvl[NC], act_mode[NC], act_lvl[NC], ramp[NC];
   bit   up[NC];
   bit   phase;
   bit   model_ok = 0;
   logic [5:0] exp_led_lo, exp_led_hi;

   function automatic int duty_of(input int c);
      case (act_mode[c])
         1:       return act_lvl[c];
         2:       return phase ? act_lvl[c] : 0;
         3:       return ramp[c];
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int cnt, pm, lv, f, idx;
      if (rst) begin
         k = 0;
         phase = 0;
         for (int c = 0; c < NC; c++) begin
            sh_mode[c] = 0; sh_lvl[c] = 0; act_mode[c] = 0; act_lvl[c] = 0;
            ramp[c] = 0; up[c] = 1;
         end
         exp_led_lo = 6'h3F;
         exp_led_hi = 6'h00;
         model_ok = 1;
      end else begin
         cnt = (k / PS) % LEVELS;
         for (int c = 0; c < NC; c++) begin
            exp_led_lo[c] = !(cnt < duty_of(c));
            exp_led_hi[c] =  (cnt < duty_of(c));
         end
         idx = int'(wr_ch);
         if (wr_en && idx < NC) begin
            sh_mode[idx] = int'(wr_mode);
            sh_lvl[idx]  = int'(wr_level);
         end
         if (k % FRAME_CYC == FRAME_CYC - 1) begin
            f = k / FRAME_CYC + 1;
            phase = ((f / BF) % 2) == 1;
            for (int c = 0; c < NC; c++) begin
               pm = act_mode[c];
               act_mode[c] = sh_mode[c];
               act_lvl[c]  = sh_lvl[c];
               lv = act_lvl[c];
               if (lv == 0) ramp[c] = 0;
               else if (ramp[c] > lv) ramp[c] = lv;
               else if (pm == 3) begin
                  if (up[c] && ramp[c] == lv) up[c] = 0;
                  else if (!up[c] && ramp[c] == 0) up[c] = 1;
                  ramp[c] += up[c] ? 1 : -1;
                  if (ramp[c] == lv) up[c] = 0;
                  else if (ramp[c] == 0) up[c] = 1;
               end
            end
         end
         k++;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("o_frame_lo", int'(frame_lo), int'(k % FRAME_CYC == FRAME_CYC - 1));
         chk("o_frame_hi", int'(frame_hi), int'(k % FRAME_CYC == FRAME_CYC - 1));
         chk("o_led_lo",   int'(led_lo),   int'(exp_led_lo));
         chk("o_led_hi",   int'(led_hi),   int'(exp_led_hi));
      end
   end

   // ---------------- directed stimulus ----------------
   int meas_lo[8], meas_hi[8];

   task automatic wr(input int ch, input int mode, input int lvl);
      int n = 0;
      while (frame_lo && n < 4) begin @(negedge clk); n++; end
      wr_en = 1'b1; wr_ch = 5'(ch); wr_mode = 2'(mode); wr_level = 4'(lvl);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int n = 0;
      while (!frame_lo && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk(name, 0, 1);
   endtask

   // Lit-cycle counts for nfr consecutive frames starting at the next boundary.
   task automatic measure(input int ch, input int nfr);
      wait_frame("measure_timeout");
      @(negedge clk);
      for (int f = 0; f < nfr; f++) begin
         meas_lo[f] = 0; meas_hi[f] = 0;
         for (int i = 0; i < LEVELS; i++) begin
            @(negedge clk);
            if (led_lo[ch] == 1'b0) meas_lo[f]++;
            if (led_hi[ch] == 1'b1) meas_hi[f]++;
         end
      end
   endtask

   task automatic sync_mid();
      wait_frame("sync_timeout");
      repeat (3) @(negedge clk);
   endtask

   initial begin
      automatic int breathe_exp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_level = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // static duty
      wr(0, 1, 4);
      measure(0, 2);
      chk("on4_f0_lo", meas_lo[0], 4);
      chk("on4_f1_lo", meas_lo[1], 4);
      chk("on4_f0_hi", meas_hi[0], 4);
      wr(0, 1, 0);
      measure(0, 1);
      chk("on0_lo", meas_lo[0], 0);
      chk("on0_hi", meas_hi[0], 0);
      wr(0, 1, 15);
      measure(0, 1);
      chk("on15_lo", meas_lo[0], 15);
      chk("on15_hi", meas_hi[0], 15);

      // shadow: last write in a frame wins
      sync_mid();
      wr(2, 1, 8);
      wr(2, 1, 2);
      measure(2, 1);
      chk("shadow_last_wins", meas_lo[0], 2);

      // blink, BLINK_FRAMES=2
      wr(1, 2, 15);
      measure(1, 8);
      for (int i = 0; i < 4; i++) begin
         chk("blink_value", int'(meas_lo[i] == 0 || meas_lo[i] == 15), 1);
         chk("blink_period", meas_lo[i], meas_lo[i + 4]);
         chk("blink_half", int'(meas_lo[i] != meas_lo[i + 2]), 1);
      end

      // breathe level 3
      wr(3, 3, 3);
      measure(3, 8);
      for (int i = 0; i < 8; i++) chk("breathe_duty", meas_lo[i], breathe_exp[i]);

      // write coincident with the boundary takes effect in that boundary
      wait_frame("coincide_timeout");
      wr_en = 1'b1; wr_ch = 5'd4; wr_mode = 2'd1; wr_level = 4'd9;
      @(negedge clk);
      wr_en = 1'b0;
      meas_lo[0] = 0;
      for (int i = 0; i < LEVELS; i++) begin
         @(negedge clk);
         if (led_lo[4] == 1'b0) meas_lo[0]++;
      end
      chk("coincident_write", meas_lo[0], 9);

      // out-of-range channel is ignored
      sync_mid();
      wr(7, 1, 15);
      wr(6, 1, 7);
      measure(5, 1);
      chk("invalid_ch5", meas_lo[0], 0);
      measure(0, 1);
      chk("invalid_ch0", meas_lo[0], 15);

      // reset mid-frame
      sync_mid();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_led_lo", int'(led_lo), 63);
         chk("rst_led_hi", int'(led_hi), 0);
         chk("rst_frame", int'(frame_lo), 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("post_rst_frame", int'(frame_lo), 0);
         chk("post_rst_led", int'(led_lo), 63);
         @(negedge clk);
      end
      chk("first_frame", int'(frame_lo), 1);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
